// File: rtl/muxadd_pkg.sv
// Shared types and helpers for the muxADD run controller.
package muxadd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Widest select the bit-reverse helper handles.
    localparam int unsigned SEL_MAXW = 16;
    // Drain counter width; output latency is at most 3 cycles.
    localparam int unsigned DRAIN_W  = 2;

    // Sobol dimension-1 point: reverse the low w bits of the index.
    function automatic logic [SEL_MAXW-1:0] bitrev(input logic [SEL_MAXW-1:0] v,
                                                   input int unsigned        w);
        logic [SEL_MAXW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < w; i++) begin
            r[i] = v[w-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/muxadd_sched_if.sv
// Job request and result handshake bundle for muxadd_sched.
interface muxadd_sched_if #(
    parameter int unsigned CWIDTH = 8
) ();
    localparam int unsigned LW = $clog2(CWIDTH + 1);

    logic              start_valid;
    logic              start_ready;
    logic [LW-1:0]     len_log;
    logic [CWIDTH:0]   result;
    logic [CWIDTH:0]   result_len;
    logic              result_valid;
    logic              result_ready;

    modport master (
        output start_valid, len_log, result_ready,
        input  start_ready, result, result_len, result_valid
    );

    modport slave (
        input  start_valid, len_log, result_ready,
        output start_ready, result, result_len, result_valid
    );
endinterface

// File: rtl/muxadd_sobol_sel.sv
// Clearable window index counter with bit-reversed select output.
module muxadd_sobol_sel
    import muxadd_pkg::*;
#(
    parameter int unsigned INUM    = 4,
    parameter int unsigned LOGINUM = 2,
    parameter int unsigned CNT_W   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    output logic [CNT_W-1:0]   idx,
    output logic [LOGINUM-1:0] sel
);

    // Index restarts at zero for every job so each run is repeatable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + CNT_W'(1);
        end
    end

    // Select follows the index directly, so it holds while the index holds.
    always_comb begin
        sel = LOGINUM'(bitrev(SEL_MAXW'(idx), $clog2(INUM)));
    end

endmodule

// File: rtl/muxadd_sched.sv
// Run controller for a mux-based scaled stochastic adder: issues a Sobol
// select window, counts ones on the adder output, returns the count.
module muxadd_sched
    import muxadd_pkg::*;
#(
    parameter int unsigned INUM    = 4,
    parameter int unsigned LOGINUM = 2,
    parameter int unsigned CWIDTH  = 8,
    parameter int unsigned OUT_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    muxadd_sched_if.slave      bus,
    input  logic               abort,
    output logic [LOGINUM-1:0] sel,
    output logic               adder_en,
    input  logic               sum_bit,
    output logic               busy
);

    localparam int unsigned CNT_W = CWIDTH + 1;
    localparam int unsigned LW    = $clog2(CWIDTH + 1);

    state_t             state, state_nxt;
    logic [LW-1:0]      win_log;
    logic [CNT_W-1:0]   idx, ones, ones_nxt, win_len;
    logic [DRAIN_W-1:0] dcnt;
    logic               samp_en, start_hs, last, idx_en;

    // Index stops at the last sample so sel holds through DRAIN and DONE.
    muxadd_sobol_sel #(
        .INUM    (INUM),
        .LOGINUM (LOGINUM),
        .CNT_W   (CNT_W)
    ) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_hs),
        .en    (idx_en),
        .idx   (idx),
        .sel   (sel)
    );

    // Decode handshake, window end and state-driven outputs.
    always_comb begin
        start_hs         = (state == IDLE) && bus.start_valid;
        win_len          = CNT_W'(1) << win_log;
        last             = (idx == win_len - CNT_W'(1));
        idx_en           = (state == RUN) && !last && !abort;
        adder_en         = (state == RUN);
        busy             = (state == RUN) || (state == DRAIN);
        bus.start_ready  = (state == IDLE);
        bus.result_valid = (state == DONE);
        ones_nxt         = ones + CNT_W'(samp_en & sum_bit);
    end

    // Next-state logic; abort wins over result_ready.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_hs) state_nxt = RUN;
            RUN:   if (abort) state_nxt = IDLE;
                   else if (last) state_nxt = (OUT_LAT == 0) ? DONE : DRAIN;
            DRAIN: if (abort) state_nxt = IDLE;
                   else if (dcnt == DRAIN_W'(OUT_LAT - 1)) state_nxt = DONE;
            DONE:  if (abort || bus.result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Job setup, ones accumulation, drain count and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_log        <= '0;
            ones           <= '0;
            dcnt           <= '0;
            bus.result     <= '0;
            bus.result_len <= '0;
        end else begin
            if (start_hs) begin
                win_log <= (bus.len_log > LW'(CWIDTH)) ? LW'(CWIDTH) : bus.len_log;
                ones    <= '0;
                dcnt    <= '0;
            end else begin
                ones <= ones_nxt;
                if (state == DRAIN) dcnt <= dcnt + DRAIN_W'(1);
            end
            // The final sample lands on the same edge that enters DONE.
            if ((state != DONE) && (state_nxt == DONE)) begin
                bus.result     <= ones_nxt;
                bus.result_len <= win_len;
            end
        end
    end

    // Delay adder_en by the adder output latency to qualify sum_bit.
    if (OUT_LAT == 0) begin : g_nolat
        always_comb samp_en = adder_en;
    end else begin : g_lat
        logic [OUT_LAT-1:0] pipe;
        // Shift register; abort flushes samples still in flight.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)     pipe <= '0;
            else if (abort) pipe <= '0;
            else            pipe <= (pipe << 1) | OUT_LAT'(adder_en);
        end
        always_comb samp_en = pipe[OUT_LAT-1];
    end

endmodule

// File: doc/muxadd_sched.md
Name: muxadd_sched

Overview:
- Run controller for a mux-based scaled stochastic adder in the scu muxADD family.
- Per job, it drives the adder's select for a bitstream window of 2^len_log cycles, then counts the ones on the adder output bit.
- It returns the binary count through a valid/ready handshake.
- The select sequence is a 1-D Sobol sequence, i.e. the bit-reversed cycle index. It restarts at index 0 for every job, so results are repeatable.

Parameters:
- INUM, 4, number of adder inputs (power of two, >=2).
- LOGINUM, 2, log2(INUM); sets the sel width.
- CWIDTH, 8, maximum log2 window length; the counters are CWIDTH+1 bits wide.
- OUT_LAT, 1, cycles from sel change to the matching sum_bit (muxADD output register); range 0..3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_valid  in  1  job request
- start_ready  out  1  high only in IDLE
- len_log  in  $clog2(CWIDTH+1)  log2 window length; sampled on the start handshake; values >CWIDTH are clamped to CWIDTH
- abort  in  1  cancel the current job
- sel  out  LOGINUM  adder select
- adder_en  out  1  high while the window is issuing
- sum_bit  in  1  adder output bitstream
- busy  out  1  high in RUN or DRAIN
- result  out  CWIDTH+1  count of ones in the window
- result_len  out  CWIDTH+1  window length, 2^len_log
- result_valid  out  1  high in DONE
- result_ready  in  1  consumer accept

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. All state goes to IDLE.
- Reset values: sel=0, adder_en=0, busy=0, result=0, result_len=0, result_valid=0. start_ready=1 once IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start_valid&&start_ready latches L=min(len_log,CWIDTH).
  - It clears idx, ones and the drain counter, then goes to RUN next cycle.
- RUN, one sample per cycle:
  - adder_en=1.
  - sel = bit-reverse of idx[LOGINUM-1:0]; for INUM=4 the sequence is 0,2,1,3,0,…
  - idx increments each cycle.
  - When idx==2^L-1, the next state is DRAIN, or DONE if OUT_LAT==0.
- Sampling:
  - adder_en is delayed OUT_LAT cycles through a shift register to give samp_en.
  - On each samp_en cycle, ones += sum_bit. Bits outside samp_en are ignored.
- DRAIN:
  - adder_en=0 and sel holds its last value.
  - Stays OUT_LAT cycles until the samp_en pipe empties, then goes to DONE.
- DONE:
  - result=ones and result_len=2^L are held stable; result_valid=1.
  - On result_ready, the next state is IDLE and result_valid falls the next cycle.
- Latency: start handshake to first result_valid = 2^L + OUT_LAT + 1 cycles.
- Width rules: ones saturates naturally because max = 2^CWIDTH fits in CWIDTH+1 bits. Arithmetic is unsigned only.
- Boundaries:
  - L=0 gives a single-cycle window with sel=0.
  - L<LOGINUM means sel does not cover all inputs. This is legal; no error is flagged.
  - idx wraps only by FSM exit; it never rolls over inside a window.
- Abort:
  - In RUN or DRAIN: next state is IDLE. adder_en and samp_en clear immediately, and the pipe is flushed.
  - result and result_valid are unaffected; the previous result is not re-presented.
  - In DONE: drops the result and goes to IDLE.
  - In IDLE: ignored.
- Simultaneous events:
  - abort has priority over result_ready and start.
  - start_valid outside IDLE is not accepted and must be held by the requester.
- Reset mid-run: asynchronous return to IDLE with the reset values above. No partial result is presented.

Decomposition:
- Shared package muxadd_pkg:
  - state enum typedef (IDLE/RUN/DRAIN/DONE).
  - function bitrev(idx) for the Sobol dim-1 select.
  - localparams for the counter widths.
- One sub-module, muxadd_sobol_sel: clear/enable index counter plus bit-reverse output. It replaces a free-running RNG so every job restarts at index 0.

Test Plan:
- INUM=4, OUT_LAT=1, stub adder = registered in[sel], in=4'b1111, len_log=8 -> result=256, result_len=256, result_valid at cycle 258 after the handshake.
- Same setup, in=4'b0011, len_log=8 -> sel sequence 0,2,1,3…, result=128; len_log=2 -> result=2.
- len_log=0, in=4'b0001 -> exactly one adder_en cycle, sel=0, result=1, result_len=1; len_log=15 -> clamped to 8, result_len=256.
- Hold result_ready=0 for 20 cycles in DONE -> result/result_valid stable; start_ready=0 and start_valid ignored; release -> IDLE one cycle later.
- abort asserted at RUN cycle 10 -> adder_en=0 next cycle, IDLE, no result_valid; a following job returns a correct fresh count with sel restarting at 0.
- rst_n dropped mid-DRAIN -> all outputs at reset values immediately; no result after release.
